// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
// Holds the default datapath/register-address widths, the ALU function codes
// (ADD doubles as the bubble code) and the ALU operand-source encodings.
package mips_pkg;

    localparam int unsigned DEF_DW = 32;
    localparam int unsigned DEF_RW = 5;

    // ALU function codes; ADD = 0 is what a bubble presents to the ALU.
    localparam logic [5:0] ALUFUN_ADD = 6'b000000;
    localparam logic [5:0] ALUFUN_SUB = 6'b000001;
    localparam logic [5:0] ALUFUN_AND = 6'b011000;
    localparam logic [5:0] ALUFUN_OR  = 6'b011110;
    localparam logic [5:0] ALUFUN_XOR = 6'b010110;
    localparam logic [5:0] ALUFUN_NOR = 6'b010001;
    localparam logic [5:0] ALUFUN_A   = 6'b011010;
    localparam logic [5:0] ALUFUN_SLL = 6'b100000;
    localparam logic [5:0] ALUFUN_SRL = 6'b100001;
    localparam logic [5:0] ALUFUN_SRA = 6'b100011;
    localparam logic [5:0] ALUFUN_EQ  = 6'b110011;
    localparam logic [5:0] ALUFUN_NEQ = 6'b110001;
    localparam logic [5:0] ALUFUN_LT  = 6'b110101;
    localparam logic [5:0] ALUFUN_LEZ = 6'b111101;
    localparam logic [5:0] ALUFUN_GEZ = 6'b111001;
    localparam logic [5:0] ALUFUN_GTZ = 6'b111111;

    typedef enum logic {
        ASRC_RS    = 1'b0,
        ASRC_SHAMT = 1'b1
    } asrc_t;

    typedef enum logic [1:0] {
        BSRC_RT  = 2'b00,
        BSRC_IMM = 2'b01,
        BSRC_LUI = 2'b10,
        BSRC_RSV = 2'b11
    } bsrc_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one source register.
// Ports:
//   src_addr                         source register index latched in ID/EX
//   reg_data                         regfile data latched in ID/EX
//   exmem_regwrite/wr_addr/result    EX/MEM writer
//   memwb_regwrite/wr_addr/result    MEM/WB writer
//   fwd_data                         value the operand should use
// EX/MEM is younger than MEM/WB and therefore wins; register 0 never forwards.
module fwd_unit #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src_addr,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_wr_addr,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_wr_addr,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd_data
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_regwrite && (exmem_wr_addr != '0) && (exmem_wr_addr == src_addr);
    assign hit_memwb = memwb_regwrite && (memwb_wr_addr != '0) && (memwb_wr_addr == src_addr);

    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem)
            fwd_data = exmem_result;
        else if (hit_memwb)
            fwd_data = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand-select stage.
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   id_*                       decoded fields of the instruction in ID
//   hold                       global freeze, all registers keep value
//   flush                      squash the instruction entering EX
//   exmem_*, memwb_*           downstream writers used for forwarding
//   stall_req                  load-use stall request to PC and IF/ID
//   alu_a/alu_b/alu_alufun/alu_sign   ALU inputs
//   ex_store_data              forwarded rt for stores
//   ex_valid/ex_wr_addr/ex_regwrite/ex_memread/ex_memwrite   EX controls
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned RW = DEF_RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm16,
    input  logic [4:0]    id_shamt,
    input  logic          id_extop,
    input  logic          id_asrc,
    input  logic [1:0]    id_bsrc,
    input  logic [5:0]    id_alufun,
    input  logic          id_sign,
    input  logic [RW-1:0] id_wr_addr,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          hold,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_wr_addr,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_wr_addr,
    input  logic [DW-1:0] memwb_result,
    output logic          stall_req,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_alufun,
    output logic          alu_sign,
    output logic [DW-1:0] ex_store_data,
    output logic          ex_valid,
    output logic [RW-1:0] ex_wr_addr,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite
);

    logic [RW-1:0] ex_rs_addr;
    logic [RW-1:0] ex_rt_addr;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [DW-1:0] ex_imm32;
    logic [4:0]    ex_shamt;
    asrc_t         ex_asrc;
    bsrc_t         ex_bsrc;
    logic [5:0]    ex_alufun;
    logic          ex_sign;

    logic [DW-1:0] id_imm32;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic          load_use;
    logic          bubble;

    // Extension is done before the register so EX only sees a ready imm32.
    assign id_imm32 = id_extop ? {{(DW-16){id_imm16[15]}}, id_imm16}
                               : {{(DW-16){1'b0}}, id_imm16};

    assign load_use = ex_valid && ex_memread && (ex_wr_addr != '0) &&
                      ((id_uses_rs && (ex_wr_addr == id_rs_addr)) ||
                       (id_uses_rt && (ex_wr_addr == id_rt_addr)));

    assign stall_req = id_valid && !flush && load_use;

    // A bubble zeroes every field, so forwarding sees register 0 and yields 0.
    assign bubble = flush || stall_req;

    always_ff @(posedge clk) begin
        if (!reset || (!hold && bubble)) begin
            ex_valid    <= 1'b0;
            ex_rs_addr  <= '0;
            ex_rt_addr  <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm32    <= '0;
            ex_shamt    <= '0;
            ex_asrc     <= ASRC_RS;
            ex_bsrc     <= BSRC_RT;
            ex_alufun   <= ALUFUN_ADD;
            ex_sign     <= 1'b0;
            ex_wr_addr  <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_rs_addr  <= id_rs_addr;
            ex_rt_addr  <= id_rt_addr;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm32    <= id_imm32;
            ex_shamt    <= id_shamt;
            ex_asrc     <= asrc_t'(id_asrc);
            ex_bsrc     <= bsrc_t'(id_bsrc);
            ex_alufun   <= id_alufun;
            ex_sign     <= id_sign;
            ex_wr_addr  <= id_wr_addr;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
        end
    end

    fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src_addr       (ex_rs_addr),
        .reg_data       (ex_rs_data),
        .exmem_regwrite (exmem_regwrite),
        .exmem_wr_addr  (exmem_wr_addr),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_wr_addr  (memwb_wr_addr),
        .memwb_result   (memwb_result),
        .fwd_data       (fwd_rs)
    );

    fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src_addr       (ex_rt_addr),
        .reg_data       (ex_rt_data),
        .exmem_regwrite (exmem_regwrite),
        .exmem_wr_addr  (exmem_wr_addr),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_wr_addr  (memwb_wr_addr),
        .memwb_result   (memwb_result),
        .fwd_data       (fwd_rt)
    );

    // Shift amount goes on a; the shifter takes its data operand on b.
    always_comb begin
        alu_a = fwd_rs;
        if (ex_asrc == ASRC_SHAMT)
            alu_a = {{(DW-5){1'b0}}, ex_shamt};
    end

    always_comb begin
        alu_b = '0;
        unique case (ex_bsrc)
            BSRC_RT:  alu_b = fwd_rt;
            BSRC_IMM: alu_b = ex_imm32;
            BSRC_LUI: alu_b = ex_imm32 << 16;
            BSRC_RSV: alu_b = '0;
        endcase
    end

    assign alu_alufun    = ex_alufun;
    assign alu_sign      = ex_sign;
    assign ex_store_data = fwd_rt;

endmodule
